// File: rtl/bus_pkg.sv
// Shared constants and types for the round-robin system-bus arbiter.
package bus_pkg;

    localparam int BUS_N_MASTER = 4;
    localparam int BUS_IDX_W    = 2;
    localparam int BUS_TIMEOUT  = 1024;
    localparam int BUS_TMR_W    = 11;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bus_op_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester found scanning last+1, last+2, ... with wrap.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N_MASTER = BUS_N_MASTER,
    parameter int IDX_W    = BUS_IDX_W
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic [IDX_W-1:0]    pick_idx,
    output logic                found
);

    int cand;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = N_MASTER; k >= 1; k--) begin
            cand = (int'(last) + k) % N_MASTER;
            if (req[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter granting the system bus to one of N masters for a whole burst.
// Optional hold-time watchdog is built when BUS_ARB_WATCHDOG_EN is defined.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTER = BUS_N_MASTER,
    parameter int IDX_W    = BUS_IDX_W
`ifdef BUS_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT  = BUS_TIMEOUT,
    parameter int TMR_W    = BUS_TMR_W
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_MASTER-1:0] master_rreq,
    input  logic [N_MASTER-1:0] master_wreq,
    input  logic                slave_busy_any,
    output logic [N_MASTER-1:0] master_acc,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid,
    output logic                bus_rreq,
    output logic                bus_wreq,
    output logic                master_busy,
    output logic                arb_fault,
    output logic [IDX_W-1:0]    fault_idx,
    output arb_state_e          dbg_state
);

    arb_state_e          state_q, state_d;
    logic [N_MASTER-1:0] req;
    logic [N_MASTER-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                valid_q, valid_d;
    bus_op_e             op_q, op_d;
    logic                fault_q, fault_d;
    logic [IDX_W-1:0]    fault_idx_q, fault_idx_d;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                timeout_hit;

    assign req = master_rreq | master_wreq;

    rr_pick #(
        .N_MASTER (N_MASTER),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req      (req),
        .last     (last_q),
        .pick_idx (pick_idx),
        .found    (pick_found)
    );

`ifdef BUS_ARB_WATCHDOG_EN
    logic [TMR_W-1:0] timer_q, timer_d;

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    // Counts grant cycles of the current owner; restarted on every new grant.
    always_comb begin
        timer_d = timer_q;
        if (state_q == ARB_IDLE) begin
            timer_d = '0;
        end else if (state_q == ARB_GRANT && !timeout_hit) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        last_d      = last_q;
        op_d        = op_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !slave_busy_any) begin
                    acc_d   = {{(N_MASTER-1){1'b0}}, 1'b1} << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    last_d  = pick_idx;
                    // Write wins when a master raises both lines together.
                    op_d    = master_wreq[pick_idx] ? OP_WRITE : OP_READ;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!req[idx_q] || timeout_hit) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    op_d    = OP_READ;
                    state_d = ARB_RELEASE;
                    if (req[idx_q]) begin
                        fault_d     = 1'b1;
                        fault_idx_d = idx_q;
                    end
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= IDX_W'(N_MASTER - 1);
            op_q        <= OP_READ;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            op_q        <= op_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
        end
    end

    assign master_acc  = acc_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign bus_rreq    = valid_q && (op_q == OP_READ);
    assign bus_wreq    = valid_q && (op_q == OP_WRITE);
    assign master_busy = valid_q || (state_q == ARB_RELEASE);
    assign arb_fault   = fault_q;
    assign fault_idx   = fault_idx_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Build with BUS_ARB_WATCHDOG_EN to exercise the watchdog at a 16-cycle timeout.
module tb_bus_rr_arbiter;
    import bus_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int OW = N + IW + 5 + IW;
`ifdef BUS_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
    localparam int TMO   = 16;
`else
    localparam bit WD_EN = 1'b0;
    localparam int TMO   = 1024;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  master_rreq, master_wreq;
    logic          slave_busy_any;
    logic [N-1:0]  master_acc;
    logic [IW-1:0] grant_idx, fault_idx;
    logic          grant_valid, bus_rreq, bus_wreq, master_busy, arb_fault;
    arb_state_e    dbg_state;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .N_MASTER (N),
        .IDX_W    (IW)
`ifdef BUS_ARB_WATCHDOG_EN
        ,
        .TIMEOUT  (TMO),
        .TMR_W    (11)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .master_rreq    (master_rreq),
        .master_wreq    (master_wreq),
        .slave_busy_any (slave_busy_any),
        .master_acc     (master_acc),
        .grant_idx      (grant_idx),
        .grant_valid    (grant_valid),
        .bus_rreq       (bus_rreq),
        .bus_wreq       (bus_wreq),
        .master_busy    (master_busy),
        .arb_fault      (arb_fault),
        .fault_idx      (fault_idx),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    logic [IW-1:0] grant_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // ---------------- reference model ----------------
    // owner: master holding the bus (-1 none); rel: the post-burst idle cycle is pending.
    int m_owner, m_last, m_hold, m_fidx;
    bit m_rel, m_opw, m_fault;

    function logic [OW-1:0] model_outputs();
        logic [N-1:0]  acc;
        logic [IW-1:0] gi;
        bit            gv;
        gv  = (m_owner >= 0);
        acc = gv ? (N'(1) << m_owner) : '0;
        gi  = gv ? IW'(m_owner) : '0;
        return {acc, gi, gv, gv && !m_opw, gv && m_opw, gv || m_rel, m_fault, IW'(m_fidx)};
    endfunction

    function void model_edge();
        logic [N-1:0] r;
        bit           found;
        r = master_rreq | master_wreq;
        if (!reset) begin
            m_owner = -1; m_rel = 0; m_last = N - 1; m_hold = 0;
            m_opw = 0; m_fault = 0; m_fidx = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_rel = 1;
            end else if (WD_EN && m_hold == TMO - 1) begin
                m_fault = 1; m_fidx = m_owner; m_owner = -1; m_rel = 1;
            end else begin
                m_hold++;
            end
        end else if (m_rel) begin
            m_rel = 0;
        end else if (r != '0 && !slave_busy_any) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && r[(m_last + k) % N]) begin
                    found   = 1;
                    m_owner = (m_last + k) % N;
                end
            end
            m_opw  = master_wreq[m_owner];
            m_last = m_owner;
            m_hold = 0;
            grant_q.push_back(IW'(m_owner));
        end
        exp_q.push_back(model_outputs());
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
    endtask

    // ---------------- monitor ----------------
    logic [OW-1:0] mon_act, mon_exp;
    logic [IW-1:0] mon_gexp;
    logic          prev_gv = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {master_acc, grant_idx, grant_valid, bus_rreq, bus_wreq,
                           master_busy, arb_fault, fault_idx};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got acc=%b idx=%0d gv=%b r=%b w=%b busy=%b flt=%b fidx=%0d, expected %b",
                             cycle, master_acc, grant_idx, grant_valid, bus_rreq, bus_wreq,
                             master_busy, arb_fault, fault_idx, mon_exp);
                end
            end
            if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
                checks++;
                if (grant_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order cycle %0d: got grant to %0d, expected no grant", cycle, grant_idx);
                end else begin
                    mon_gexp = grant_q.pop_front();
                    if (grant_idx !== mon_gexp) begin
                        errors++;
                        $display("FAIL grant_order cycle %0d: got %0d expected %0d", cycle, grant_idx, mon_gexp);
                    end
                end
            end
            prev_gv = grant_valid;
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] dropped;

    initial begin
        reset          = 1'b0;
        master_rreq    = '0;
        master_wreq    = '0;
        slave_busy_any = 1'b0;
        dropped        = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single master read burst
        master_rreq = 4'b0100;
        repeat (6) tick();
        master_rreq = '0;
        repeat (4) tick();

        // all masters writing, each drops after 4 grant cycles and returns a cycle later
        master_wreq = 4'b1111;
        repeat (40) begin
            tick();
            master_wreq = master_wreq | dropped;
            dropped     = '0;
            if (m_owner >= 0 && m_hold == 3) begin
                master_wreq[m_owner] = 1'b0;
                dropped[m_owner]     = 1'b1;
            end
        end
        master_wreq = '0;
        repeat (4) tick();

        // op latched at grant: write stays even after wreq drops mid-burst
        master_rreq[1] = 1'b1;
        master_wreq[1] = 1'b1;
        repeat (3) tick();
        master_wreq[1] = 1'b0;
        repeat (4) tick();
        master_rreq = '0;
        repeat (3) tick();

        // slave busy blocks new grants
        slave_busy_any = 1'b1;
        master_rreq    = 4'b0001;
        repeat (10) tick();
        slave_busy_any = 1'b0;
        repeat (3) tick();
        master_rreq = '0;
        repeat (3) tick();

        // reset in the middle of a burst
        master_rreq = 4'b1000;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        master_rreq = 4'b1001;
        repeat (3) tick();
        master_rreq = '0;
        repeat (4) tick();

        // long hold by master 2 with master 3 pending
        master_wreq[2] = 1'b1;
        repeat (2) tick();
        master_rreq[3] = 1'b1;
        repeat (24) tick();
        master_wreq = '0;
        master_rreq = '0;
        repeat (6) tick();

        // random traffic
        repeat (600) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) master_rreq[i] = ~master_rreq[i];
                if ($urandom_range(0, 9) == 0) master_wreq[i] = ~master_wreq[i];
            end
            slave_busy_any = ($urandom_range(0, 5) == 0);
            tick();
        end
        master_rreq    = '0;
        master_wreq    = '0;
        slave_busy_any = 1'b0;
        repeat (6) tick();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || grant_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d output and %0d grant entries left, expected 0 and 0",
                     exp_q.size(), grant_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin arbiter that shares the single system bus between N masters, each with rreq/wreq request lines.
- Issues a one-hot master_acc grant and holds it for the whole burst, until the granted master drops its request.
- Drives the muxed bus-side rreq/wreq and grant index that the bus controller's address/data muxes and slave decode use.
- Sits between the master request lines and the BusController datapath.

Parameters:
N_MASTER, 4, number of requesting masters.
IDX_W, 2, width of grant index (clog2 of N_MASTER).
TIMEOUT, 1024, max cycles a grant may be held before a fault (only with watchdog).
TMR_W, 11, width of hold timer; must be able to hold TIMEOUT.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (one clock; reset sampled on rising clk edge, asserted when 0)
master_rreq  in  N_MASTER  per-master read request, held for the full burst
master_wreq  in  N_MASTER  per-master write request, held for the full burst
slave_busy_any  in  1  OR of slave busy lines; blocks new grants while high
master_acc  out  N_MASTER  one-hot grant
grant_idx  out  IDX_W  index of granted master, valid while grant_valid
grant_valid  out  1  a grant is active
bus_rreq  out  1  read request forwarded to slaves
bus_wreq  out  1  write request forwarded to slaves
master_busy  out  1  high when grant_valid or in RELEASE
arb_fault  out  1  sticky hold-timeout flag (watchdog build only, else tied 0)
fault_idx  out  IDX_W  master that caused the fault

Behaviour:
- Reset (reset==0 at a clk edge):
  - master_acc=0, grant_idx=0, grant_valid=0, bus_rreq=0, bus_wreq=0, master_busy=0, arb_fault=0, fault_idx=0.
  - last pointer = N_MASTER-1, so master 0 wins first. State=IDLE.
- Request vector: req[i] = master_rreq[i] | master_wreq[i].
- IDLE:
  - If any req and !slave_busy_any: pick the first requesting i scanning last+1, last+2, … (mod N_MASTER, wrap-around).
  - Register master_acc=1<<i, grant_idx=i, grant_valid=1. Latch op: wreq wins if both are set. bus_wreq/bus_rreq follow the latched op. last=i. Go to GRANT.
  - Grant latency: one cycle from request to master_acc high.
- GRANT:
  - Hold grant while req[grant_idx]=1. Requests from other masters are ignored; no preemption.
  - Changes to the granted master's rreq/wreq mid-burst do not change the latched op.
  - When req[grant_idx]=0: drop master_acc, bus_rreq, bus_wreq and grant_valid on the next edge. Go to RELEASE.
- RELEASE:
  - One mandatory idle cycle (master_busy=1, no grant), giving slaves one cycle to see deasserted req. Then IDLE.
  - Back-to-back same master: regrant 2 cycles after its req drops, only if no other master is requesting.
- slave_busy_any high in IDLE: no grant issued. Requests stay pending and nothing is lost, since requests are levels.
- Simultaneous requests from all masters: strict rotation 0,1,2,3,0…
- A master that drops req before being granted simply loses its turn; no state is kept.
- Reset mid-GRANT: immediate return to reset values. The masters' outstanding bursts are abandoned.

Optional Feature:
Macro BUS_ARB_WATCHDOG_EN.
- Defined:
  - hold timer clears on entering GRANT and increments each GRANT cycle.
  - When timer reaches TIMEOUT-1 and req is still held: set arb_fault=1 (sticky until reset) and fault_idx=grant_idx. Force RELEASE, then resume normal rotation with last=faulting master.
- Not defined:
  - no timer logic.
  - arb_fault and fault_idx tied 0; grants are held indefinitely.

Decomposition:
- Shared package bus_pkg:
  - N_MASTER, IDX_W, and TIMEOUT default constants.
  - arbiter state enum {ARB_IDLE, ARB_GRANT, ARB_RELEASE}.
  - bus op typedef {OP_READ, OP_WRITE}.
- One natural sub-module: rr_pick, a combinational rotate/priority-encode of req given last.
  - Returns the granted index plus a found flag.

Test Plan:
1. Single master: after reset release, master_rreq=4'b0100 held 6 cycles → master_acc=4'b0100 one cycle later, grant_idx=2, bus_rreq=1 for 6 cycles, bus_wreq=0. Then 1 RELEASE cycle with master_busy=1, then master_busy=0.
2. All-request fairness: master_wreq=4'b1111, each master drops req 4 cycles after its own acc and re-raises it 1 cycle later → grant order 0,1,2,3,0,1. No master is ever granted twice in a row.
3. Op latch: master 1 asserts rreq and wreq together, then drops wreq mid-burst → bus_wreq=1, bus_rreq=0 for the entire grant.
4. Slave busy gating: slave_busy_any=1 while master_rreq=4'b0001 for 10 cycles → master_acc stays 0. Grant appears 1 cycle after slave_busy_any falls.
5. Reset mid-burst: master 3 granted, reset=0 for one edge → all outputs 0 next cycle. After reset, with masters 0 and 3 requesting, master 0 is granted first.
6. Watchdog (BUS_ARB_WATCHDOG_EN, TIMEOUT=16): master 2 holds wreq forever → arb_fault=1 and fault_idx=2 after 16 grant cycles, grant dropped. A pending master 3 is granted 2 cycles later; arb_fault stays 1.
